threshold_monitor: RTL and testbench
====================================

// Module: threshold_monitor
// PURPOSE
//   Consumes temp_threshold/light_threshold from the configuration register
//   stage and compares them against streamed sensor samples.
//   Drives fan_on and lamp_on through per-channel hysteresis + persistence FSMs.
//   Filters single-sample noise and prevents output chatter near a threshold.
// PARAMETERS
//   PERSIST  4  consecutive qualifying valid samples needed to switch state (1..15)
//   HYST     2  hysteresis band width in sample LSBs (0..63)
//   OT_MARGIN 10  over-temperature margin above temp_threshold (OVERTEMP_EN only)
// PORTS
//   clk              in   1  clock
//   reset            in   1  asynchronous, active-high reset
//   temp_sample      in   8  temperature sample, unsigned
//   temp_valid       in   1  temp_sample qualifier, one-cycle strobe
//   light_sample     in   8  light sample, unsigned
//   light_valid      in   1  light_sample qualifier, one-cycle strobe
//   temp_threshold   in   8  fan switch point, from the configuration registers
//   light_threshold  in   8  lamp switch point, from the configuration registers
//   overtemp_ack     in   1  clears overtemp (OVERTEMP_EN only)
//   fan_on           out  1  fan drive
//   lamp_on          out  1  lamp drive
//   temp_state       out  2  temp FSM state: 0 OFF, 1 ARM, 2 ON, 3 DISARM
//   light_state      out  2  light FSM state, same encoding
//   overtemp         out  1  latched over-temperature flag
// BEHAVIOUR
//   - Reset: fan_on=0, lamp_on=0, temp_state=light_state=OFF, overtemp=0.
//     All persistence counters are 0. Reset mid-operation aborts any ARM/DISARM immediately.
//   - Widths: band limits are computed in 9 bits and saturate.
//     temp_lo  = max(temp_threshold-HYST, 0)
//     light_hi = min(light_threshold+HYST, 255)
//   - Qualifying conditions:
//     temp: on_cond = sample > temp_threshold; off_cond = sample < temp_lo
//     light: on_cond = sample < light_threshold; off_cond = sample > light_hi
//   - The FSMs and counters advance only on cycles where the channel's valid is 1.
//     With valid=0, all state holds.
//   - Thresholds are sampled on the same edge as the sample. A threshold change
//     takes effect on the next valid sample, and the counter is not cleared.
//   - Per-channel FSM, with cnt = persistence counter:
//     OFF:    on_cond -> cnt=1. If PERSIST==1, go to ON; otherwise go to ARM.
//     ARM:    on_cond -> cnt+1. When cnt reaches PERSIST, go to ON.
//             otherwise -> OFF, cnt=0.
//     ON:     off_cond -> cnt=1. If PERSIST==1, go to OFF; otherwise go to DISARM.
//     DISARM: off_cond -> cnt+1. When cnt reaches PERSIST, go to OFF.
//             otherwise -> ON, cnt=0.
//   - A sample inside the hysteresis band counts as "otherwise".
//   - Outputs are registered. fan_on/lamp_on = (state==ON || state==DISARM).
//     The output changes on the same edge that registers the PERSIST-th qualifying
//     sample, i.e. one cycle after that valid is seen at the inputs.
//   - The two channels are fully independent. Simultaneous valids are both processed
//     in the same cycle.
//   - cnt is 4 bits and cannot wrap, since PERSIST<=15.
// CONFIGURATION
//   THRESH_MON_OVERTEMP_EN defined:
//     - On a temp_valid with sample >= temp_threshold+OT_MARGIN (9-bit compare,
//       no saturation), overtemp sets on the next edge. This is not persistence filtered.
//     - overtemp stays set until an overtemp_ack cycle.
//     - If set and ack occur in the same cycle, set wins.
//     - While overtemp=1, fan_on is forced to 1 regardless of the FSM.
//   Not defined:
//     - overtemp is tied to 0 and overtemp_ack is ignored.
//     - The port list is unchanged.
// TESTING  (PERSIST=4, HYST=2, thresholds 30/100)
//   1. Reset released, no valids for 20 cycles -> fan_on=lamp_on=0, both states OFF.
//   2. temp 31,31,31,31 on valid -> temp_state 1,1,1,2; fan_on=1 one cycle after
//      the 4th valid. temp 31,31,31,40 instead -> no switch before the 4th sample.
//   3. fan ON, temp 29 x4 -> fan stays 1 (in band). temp 27 x4 -> DISARM, then
//      OFF, fan_on=0. temp 27,27,29,27 -> returns to ON after the 29.
//   4. light 99 x3, light 101, light 99 x4 -> lamp_on=1 only after the final 4.
//      Then light_threshold=254 with light 255 x4 -> lamp stays 1 (light_hi
//      saturates at 255).
//   5. temp_threshold=1 with fan ON and temp 0 x4 -> fan stays ON (temp_lo saturates at 0).
//      Assert reset while temp_state=ARM -> all outputs and states 0 the same cycle.
//   6. (OVERTEMP_EN) temp 40 single valid -> overtemp=1 and fan_on=1 next cycle.
//      overtemp_ack with temp 45 valid in the same cycle -> overtemp stays 1.
//      ack alone -> overtemp=0, and fan_on then follows the FSM.

Source files
------------

// File: rtl/threshold_monitor.sv
// Two-channel sensor threshold monitor: hysteresis band plus persistence filter per channel.
// Optional latched over-temperature flag is enabled by defining THRESH_MON_OVERTEMP_EN.

module threshold_chan #(
  parameter int PERSIST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       on_cond,
  input  logic       off_cond,
  output logic [1:0] state,
  output logic       active_nxt
);
  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_DISARM = 2'd3;
  localparam logic [3:0] PERSIST_C = 4'(PERSIST);
  localparam bit         SINGLE    = (PERSIST == 1);

  logic [1:0] state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;

  // State and persistence counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter update, only on valid samples
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (valid) begin
      case (state_r)
        ST_OFF: begin
          if (on_cond) begin
            cnt_nxt_s   = SINGLE ? 4'd0 : 4'd1;
            state_nxt_s = SINGLE ? ST_ON : ST_ARM;
          end else begin
            cnt_nxt_s   = 4'd0;
          end
        end
        ST_ARM: begin
          if (on_cond && (cnt_r + 4'd1 == PERSIST_C)) begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_ON;
          end else if (on_cond) begin
            cnt_nxt_s   = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_OFF;
          end
        end
        ST_ON: begin
          if (off_cond) begin
            cnt_nxt_s   = SINGLE ? 4'd0 : 4'd1;
            state_nxt_s = SINGLE ? ST_OFF : ST_DISARM;
          end else begin
            cnt_nxt_s   = 4'd0;
          end
        end
        ST_DISARM: begin
          if (off_cond && (cnt_r + 4'd1 == PERSIST_C)) begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_OFF;
          end else if (off_cond) begin
            cnt_nxt_s   = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_ON;
          end
        end
        default: begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ST_OFF;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Drive is asserted in ON and DISARM; computed from next state so the parent can register it
  always_comb begin
    active_nxt = (state_nxt_s == ST_ON) || (state_nxt_s == ST_DISARM);
  end

  assign state = state_r;
endmodule

module threshold_monitor #(
  parameter int PERSIST   = 4,
  parameter int HYST      = 2,
  parameter int OT_MARGIN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temp_sample,
  input  logic       temp_valid,
  input  logic [7:0] light_sample,
  input  logic       light_valid,
  input  logic [7:0] temp_threshold,
  input  logic [7:0] light_threshold,
  input  logic       overtemp_ack,
  output logic       fan_on,
  output logic       lamp_on,
  output logic [1:0] temp_state,
  output logic [1:0] light_state,
  output logic       overtemp
);
  logic [7:0] temp_lo_s, light_hi_s;
  logic [8:0] light_sum_s;
  logic       temp_on_s, temp_off_s, light_on_s, light_off_s;
  logic       temp_act_s, light_act_s, ot_nxt_s;
  logic       fan_on_r, lamp_on_r, overtemp_r;

  // Saturating hysteresis band edges
  always_comb begin
    light_sum_s = {1'b0, light_threshold} + 9'(HYST);
    if (temp_threshold >= 8'(HYST)) begin
      temp_lo_s = temp_threshold - 8'(HYST);
    end else begin
      temp_lo_s = 8'd0;
    end
    if (light_sum_s[8]) begin
      light_hi_s = 8'd255;
    end else begin
      light_hi_s = light_sum_s[7:0];
    end
  end

  assign temp_on_s   = temp_sample > temp_threshold;
  assign temp_off_s  = temp_sample < temp_lo_s;
  assign light_on_s  = light_sample < light_threshold;
  assign light_off_s = light_sample > light_hi_s;

  threshold_chan #(.PERSIST(PERSIST)) u_temp (
    .clk(clk), .reset(reset), .valid(temp_valid), .on_cond(temp_on_s),
    .off_cond(temp_off_s), .state(temp_state), .active_nxt(temp_act_s)
  );

  threshold_chan #(.PERSIST(PERSIST)) u_light (
    .clk(clk), .reset(reset), .valid(light_valid), .on_cond(light_on_s),
    .off_cond(light_off_s), .state(light_state), .active_nxt(light_act_s)
  );

`ifdef THRESH_MON_OVERTEMP_EN
  logic [8:0] ot_lim_s;
  logic       ot_set_s;
  assign ot_lim_s = {1'b0, temp_threshold} + 9'(OT_MARGIN);
  assign ot_set_s = temp_valid && ({1'b0, temp_sample} >= ot_lim_s);

  // Sticky flag: a set in the same cycle as an ack takes priority
  always_comb begin
    if (ot_set_s) begin
      ot_nxt_s = 1'b1;
    end else if (overtemp_ack) begin
      ot_nxt_s = 1'b0;
    end else begin
      ot_nxt_s = overtemp_r;
    end
  end
`else
  logic       unused_ack_s;
  logic [8:0] unused_margin_s;
  assign unused_ack_s    = overtemp_ack;
  assign unused_margin_s = 9'(OT_MARGIN);
  assign ot_nxt_s        = 1'b0;
`endif

  // Registered drives; overtemp forces the fan on
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fan_on_r   <= 1'b0;
      lamp_on_r  <= 1'b0;
      overtemp_r <= 1'b0;
    end else begin
      fan_on_r   <= temp_act_s | ot_nxt_s;
      lamp_on_r  <= light_act_s;
      overtemp_r <= ot_nxt_s;
    end
  end

  assign fan_on   = fan_on_r;
  assign lamp_on  = lamp_on_r;
  assign overtemp = overtemp_r;
endmodule

// File: tb/tb_threshold_monitor.sv
// Directed scoreboard bench for threshold_monitor (PERSIST=4, HYST=2, thresholds 30/100).
// Over-temperature expectations follow THRESH_MON_OVERTEMP_EN.

module tb_threshold_monitor;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] temp_sample, light_sample, temp_threshold, light_threshold;
  logic       temp_valid, light_valid, overtemp_ack;
  logic       fan_on, lamp_on, overtemp;
  logic [1:0] temp_state, light_state;

`ifdef THRESH_MON_OVERTEMP_EN
  localparam logic OT = 1'b1;
`else
  localparam logic OT = 1'b0;
`endif

  typedef struct packed {
    logic       fan;
    logic       lamp;
    logic [1:0] ts;
    logic [1:0] ls;
    logic       ot;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  threshold_monitor #(.PERSIST(4), .HYST(2), .OT_MARGIN(10)) dut (
    .clk(clk), .reset(reset),
    .temp_sample(temp_sample), .temp_valid(temp_valid),
    .light_sample(light_sample), .light_valid(light_valid),
    .temp_threshold(temp_threshold), .light_threshold(light_threshold),
    .overtemp_ack(overtemp_ack),
    .fan_on(fan_on), .lamp_on(lamp_on),
    .temp_state(temp_state), .light_state(light_state), .overtemp(overtemp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  function automatic exp_t ex(logic f, logic l, logic [1:0] t, logic [1:0] s, logic o);
    exp_t e;
    e.fan = f; e.lamp = l; e.ts = t; e.ls = s; e.ot = o;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [1:0] got, input logic [1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("fan_on", {1'b0, fan_on}, {1'b0, e.fan});
    cmp("lamp_on", {1'b0, lamp_on}, {1'b0, e.lamp});
    cmp("temp_state", temp_state, e.ts);
    cmp("light_state", light_state, e.ls);
    cmp("overtemp", {1'b0, overtemp}, {1'b0, e.ot});
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge
  task automatic step(input logic tv, input logic [7:0] ts, input logic lv,
                      input logic [7:0] ls, input logic ack, input exp_t e);
    exp_t got_e;
    temp_valid = tv; temp_sample = ts;
    light_valid = lv; light_sample = ls;
    overtemp_ack = ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    temp_valid = 1'b0; light_valid = 1'b0; overtemp_ack = 1'b0;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end
    if (sb.size() != 0) begin
      got_e = sb.pop_front();
      check_all(got_e);
    end
  endtask

  task automatic tstep(input logic [7:0] s, input exp_t e);
    step(1'b1, s, 1'b0, 8'd0, 1'b0, e);
  endtask

  task automatic lstep(input logic [7:0] s, input exp_t e);
    step(1'b0, 8'd0, 1'b1, s, 1'b0, e);
  endtask

  task automatic idle(input exp_t e);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, e);
  endtask

  initial begin
    reset = 1'b1;
    temp_valid = 1'b0; light_valid = 1'b0; overtemp_ack = 1'b0;
    temp_sample = 8'd0; light_sample = 8'd0;
    temp_threshold = 8'd30; light_threshold = 8'd100;
    repeat (2) @(posedge clk);
    #1;
    check_all(ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) idle(ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

    // Four qualifying samples switch the fan on
    for (int i = 0; i < 3; i++) tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd35, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    // Sample equal to threshold aborts ARM
    tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd30, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    // Idle cycles hold the counter
    tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) idle(ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));

    // Hysteresis band holds ON; below-band samples turn off
    for (int i = 0; i < 4; i++) tstep(8'd29, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    tstep(8'd28, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd29, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

    // Light channel, then both channels switching in the same cycles
    for (int i = 0; i < 3; i++) lstep(8'd99, ex(1'b0, 1'b0, 2'd0, 2'd1, 1'b0));
    lstep(8'd101, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    lstep(8'd100, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'd31, 1'b1, 8'd99, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd1, 1'b0));
    step(1'b1, 8'd31, 1'b1, 8'd99, 1'b0, ex(1'b1, 1'b1, 2'd2, 2'd2, 1'b0));
    light_threshold = 8'd254;
    for (int i = 0; i < 4; i++) lstep(8'd255, ex(1'b1, 1'b1, 2'd2, 2'd2, 1'b0));
    light_threshold = 8'd100;
    lstep(8'd102, ex(1'b1, 1'b1, 2'd2, 2'd2, 1'b0));
    for (int i = 0; i < 3; i++) lstep(8'd103, ex(1'b1, 1'b1, 2'd2, 2'd3, 1'b0));
    lstep(8'd103, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));

    // temp_lo saturates at zero
    temp_threshold = 8'd1;
    for (int i = 0; i < 4; i++) tstep(8'd0, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    temp_threshold = 8'd30;
    for (int i = 0; i < 3; i++) tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

    // Asynchronous reset during ARM clears everything without a clock edge
    for (int i = 0; i < 3; i++) tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    reset = 1'b1;
    #1;
    check_all(ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tstep(8'd31, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) tstep(8'd27, ex(1'b1, 1'b0, 2'd3, 2'd0, 1'b0));
    tstep(8'd27, ex(1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

    // Over-temperature set, set-beats-ack, ack release
    tstep(8'd40, ex(OT, 1'b0, 2'd1, 2'd0, OT));
    step(1'b1, 8'd45, 1'b0, 8'd0, 1'b1, ex(OT, 1'b0, 2'd1, 2'd0, OT));
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd39, ex(1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    tstep(8'd31, ex(1'b1, 1'b0, 2'd2, 2'd0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
